// File: rtl/reg_file_sweep.sv
// reg_file_sweep: WIDTH x DEPTH register file, 2 comb read ports, bypassed write port, clear sweep engine.
// Define REG_ZERO_EN to hardwire entry 0 to zero.
module reg_file_sweep #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic [AW-1:0]           RR1,
  input  logic [AW-1:0]           RR2,
  input  logic [AW-1:0]           WR,
  input  logic signed [WIDTH-1:0] WD,
  input  logic                    WE,
  input  logic                    Clr,
  output logic signed [WIDTH-1:0] Out1,
  output logic signed [WIDTH-1:0] Out2,
  output logic                    Busy
);
`ifdef REG_ZERO_EN
  localparam logic ZERO_EN = 1'b1;
`else
  localparam logic ZERO_EN = 1'b0;
`endif
  typedef enum logic {IDLE, SWEEP} state_t;
  state_t state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic signed [WIDTH-1:0] mem [DEPTH];
  logic wr_ok, mem_we;
  logic [AW-1:0] mem_wa;
  logic signed [WIDTH-1:0] mem_wd;
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      state <= SWEEP;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  // DEPTH is a power of two, so cnt wraps back to 0 on the final sweep write
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    if (state == SWEEP) begin
      cnt_nxt   = cnt + 1'b1;
      state_nxt = (cnt == AW'(DEPTH - 1)) ? IDLE : SWEEP;
    end else if (Clr) state_nxt = SWEEP;
  end
  always_comb begin
    Busy   = (state == SWEEP);
    wr_ok  = WE && !Busy && !(ZERO_EN && WR == '0);
    mem_we = Busy || wr_ok;
    mem_wa = Busy ? cnt : WR;
    mem_wd = Busy ? '0 : WD;
  end
  always_ff @(posedge Clk)
    if (mem_we) mem[mem_wa] <= mem_wd;
  always_comb begin
    Out1 = (Busy || (ZERO_EN && RR1 == '0)) ? '0 : (wr_ok && WR == RR1) ? WD : mem[RR1];
    Out2 = (Busy || (ZERO_EN && RR2 == '0)) ? '0 : (wr_ok && WR == RR2) ? WD : mem[RR2];
  end
endmodule

// File: tb/tb_reg_file_sweep.sv
// tb_reg_file_sweep: table vectors, directed sweep/reset sequences and random traffic against a reference model.
module tb_reg_file_sweep;
  localparam int DEPTH = 32;
`ifdef REG_ZERO_EN
  localparam logic Z = 1'b1;
`else
  localparam logic Z = 1'b0;
`endif
  logic Clk = 1'b0, Rst_n = 1'b0, WE = 1'b0, Clr = 1'b0, Busy;
  logic [4:0] RR1 = '0, RR2 = '0, WR = '0;
  logic signed [31:0] WD = '0, Out1, Out2;
  int checks = 0, failures = 0;
  // model: entry k is zeroed at edge sw_start+k; busy until edge sw_start+DEPTH-1 is done
  logic signed [31:0] mem_m [DEPTH];
  int ec = 0, sw_start = 1;

  reg_file_sweep dut (.Clk(Clk), .Rst_n(Rst_n), .RR1(RR1), .RR2(RR2), .WR(WR), .WD(WD),
                      .WE(WE), .Clr(Clr), .Out1(Out1), .Out2(Out2), .Busy(Busy));

  always #5 Clk = ~Clk;

  initial for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;

  always @(negedge Rst_n) sw_start = ec + 1;

  always @(posedge Clk) if (Rst_n) begin
    if (ec + 1 < sw_start + DEPTH) mem_m[ec + 1 - sw_start] = '0;
    else begin
      if (WE && !(Z && WR == 0)) mem_m[WR] = WD;
      if (Clr) sw_start = ec + 2;
    end
    ec = ec + 1;
  end

  function automatic logic m_busy();
    return (ec + 1 - sw_start) < DEPTH;
  endfunction

  function automatic logic signed [31:0] ref_rd(input logic [4:0] a);
    if (m_busy() || (Z && a == 0)) return 0;
    if (WE && WR == a && !(Z && WR == 0)) return WD;
    return mem_m[a];
  endfunction

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm);
    chk({nm, "_busy"}, 32'(Busy), 32'(m_busy()));
    chk({nm, "_out1"}, Out1, ref_rd(RR1));
    chk({nm, "_out2"}, Out2, ref_rd(RR2));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (Busy && n < 100) begin
      @(negedge Clk);
      n++;
    end
    if (Busy) chk("idle_timeout", 32'(Busy), 0);
  endtask

  typedef struct {
    logic we; logic [4:0] wr; logic signed [31:0] wd;
    logic [4:0] rr1, rr2; logic signed [31:0] e1, e2;
  } vec_t;
  vec_t tbl [8];

  initial begin
    tbl[0] = '{1'b0, 5'd0,  0,   5'd3,  5'd10, -2000, 0};
    tbl[1] = '{1'b1, 5'd10, 55,  5'd10, 5'd10, 55, 55};
    tbl[2] = '{1'b0, 5'd0,  0,   5'd10, 5'd20, 55, 0};
    tbl[3] = '{1'b1, 5'd20, 8,   5'd3,  5'd20, -2000, 8};
    tbl[4] = '{1'b1, 5'd0,  -2,  5'd0,  5'd0,  Z ? 0 : -2, Z ? 0 : -2};
    tbl[5] = '{1'b0, 5'd0,  0,   5'd0,  5'd0,  Z ? 0 : -2, Z ? 0 : -2};
    tbl[6] = '{1'b1, 5'd7,  123, 5'd6,  5'd8,  0, 0};
    tbl[7] = '{1'b0, 5'd0,  0,   5'd7,  5'd3,  123, -2000};
    // reset state, then release with a dropped write during the sweep
    repeat (2) @(negedge Clk);
    #1;
    chk("rst_busy", 32'(Busy), 1);
    chk("rst_out1", Out1, 0);
    chk("rst_out2", Out2, 0);
    @(negedge Clk);
    Rst_n = 1'b1; RR1 = 5'd7; RR2 = 5'd31; WE = 1'b1; WR = 5'd5; WD = 1300;
    for (int k = 0; k <= DEPTH; k++) begin
      if (k > 0) @(negedge Clk);
      #1;
      chk("rel_busy", 32'(Busy), 32'(k < DEPTH));
      if (k < DEPTH) begin
        chk("rel_out1", Out1, 0);
        chk("rel_out2", Out2, 0);
      end
      chk_all("rel");
    end
    WE = 1'b0; RR1 = 5'd5;
    #1 chk("drop", Out1, 0);
    for (int i = 0; i < DEPTH; i++) begin
      RR1 = 5'(i); RR2 = 5'(DEPTH - 1 - i);
      #1;
      chk("swept1", Out1, 0);
      chk("swept2", Out2, 0);
    end
    // same-cycle bypass, then the committed value
    @(negedge Clk);
    WE = 1'b1; WR = 5'd3; WD = -2000; RR1 = 5'd3;
    #1 chk("bypass", Out1, -2000);
    @(negedge Clk);
    WE = 1'b0;
    #1 chk("committed", Out1, -2000);
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      WE = tbl[i].we; WR = tbl[i].wr; WD = tbl[i].wd; RR1 = tbl[i].rr1; RR2 = tbl[i].rr2;
      #1;
      chk($sformatf("tbl%0d_out1", i), Out1, tbl[i].e1);
      chk($sformatf("tbl%0d_out2", i), Out2, tbl[i].e2);
    end
    // clear coinciding with a write, and a second Clr mid-sweep
    @(negedge Clk);
    WE = 1'b1; WR = 5'd31; WD = 1300;
    @(negedge Clk);
    WR = 5'd2; WD = 9; Clr = 1'b1;
    for (int k = 1; k <= DEPTH + 1; k++) begin
      @(negedge Clk);
      WE = 1'b0;
      Clr = (k == 10);
      #1;
      chk("clr_busy", 32'(Busy), 32'(k <= DEPTH));
      chk_all("clr");
    end
    Clr = 1'b0; RR1 = 5'd2; RR2 = 5'd31;
    #1;
    chk("clr_e2", Out1, 0);
    chk("clr_e31", Out2, 0);
    // reset pulse in the middle of a sweep restarts it
    @(negedge Clk);
    Clr = 1'b1;
    @(negedge Clk);
    Clr = 1'b0;
    repeat (10) @(negedge Clk);
    Rst_n = 1'b0;
    #1 chk("mid_rst_busy", 32'(Busy), 1);
    #1 Rst_n = 1'b1;
    for (int k = 1; k <= DEPTH; k++) begin
      @(negedge Clk);
      #1;
      chk("mid_busy", 32'(Busy), 32'(k < DEPTH));
      chk_all("mid");
    end
    // random traffic with occasional clears
    for (int i = 0; i < 400; i++) begin
      @(negedge Clk);
      WE = 1'($urandom); WR = 5'($urandom); WD = $urandom;
      RR1 = ($urandom_range(3) == 0) ? WR : 5'($urandom);
      RR2 = 5'($urandom);
      Clr = ($urandom_range(31) == 0);
      #1 chk_all("rnd");
    end
    @(negedge Clk);
    WE = 1'b0; Clr = 1'b0;
    wait_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
